led_step_sequencer: RTL and testbench
=====================================

LED_STEP_SEQUENCER -- requirements
Module: led_step_sequencer

Interface
REQ-001 SHALL have parameter CH, default 4, channel count, legal 2..16.
REQ-002 SHALL have parameter PW, default 24, period counter width in bits.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  sequence trigger; acts on its rising edge only.
REQ-006 SHALL have port STOP  input  1  level abort.
REQ-007 SHALL have port MODE  input  2  00 loop, 01 one-pass, 10 ping-pong, 11 loop.
REQ-008 SHALL have port DIR  input  1  0 ascending from LED[0], 1 descending from LED[CH-1].
REQ-009 SHALL have port PERIOD  input  PW  dwell per step in CLK cycles.
REQ-010 SHALL have port LED  output  CH  one-hot lit channel, or all zero.
REQ-011 SHALL have port BUSY  output  1  high while in RUN.
REQ-012 SHALL have port STEP  output  1  one-cycle pulse on each channel advance.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at one-pass completion.

Function
REQ-014 SHALL implement states IDLE and RUN.
REQ-015 SHALL register START and detect its rising edge as START=1 while the previous sample was 0.
REQ-016 SHALL, on a START edge in IDLE, enter RUN the next cycle: LED one-hot at the first channel, dwell counter 0, BUSY=1.
REQ-017 SHALL latch MODE, DIR and PERIOD on each accepted START edge; input changes during RUN have no effect.
REQ-018 SHALL treat a latched PERIOD of 0 as 1.
REQ-019 SHALL count dwell 0..PERIOD-1; at PERIOD-1 SHALL advance to the next channel and clear the counter, so each channel stays lit exactly PERIOD cycles.
REQ-020 SHALL pulse STEP in the same cycle LED changes channel; STEP SHALL NOT pulse on the initial light-up.
REQ-021 SHALL, in loop mode, wrap from the last channel to the first, indefinitely.
REQ-022 SHALL, in one-pass mode, clear LED, pulse DONE and return to IDLE when the last channel's dwell expires; STEP SHALL NOT pulse at that point.
REQ-023 SHALL, on a START edge in RUN, restart from the first channel with newly latched settings, with no STEP pulse.
REQ-024 SHALL, while STOP=1, go or stay in IDLE next cycle with LED=0 and BUSY=0; STOP SHALL override a simultaneous START edge, and no DONE pulse SHALL occur.

Reset
REQ-025 SHALL, while RN=0, asynchronously force IDLE, LED=0, BUSY=0, STEP=0, DONE=0, dwell counter 0, edge register 0.
REQ-026 SHALL, after RN releases with START already high, not treat that level as a rising edge.

Configuration
REQ-027 SHALL, with LED_SEQ_PINGPONG_EN defined, run MODE=10 as ping-pong: reverse direction at either end, endpoints lit once per reversal, e.g. CH=4: 0,1,2,3,2,1,0,1...
REQ-028 SHALL, without LED_SEQ_PINGPONG_EN, treat MODE=10 as loop, and SHALL contain no reversal logic.

Structure
REQ-029 SHALL take the state enum, MODE encodings and the CH legal-range constants from shared package led_seq_pkg.
REQ-030 SHALL instantiate sub-module led_seq_dwell_timer: PW-bit dwell counter with load/clear, producing the terminal-count pulse.

Verification
REQ-031 SHALL verify: CH=4, MODE=00, DIR=0, PERIOD=3, START edge -> LED 0001,0010,0100,1000,0001 every 3 cycles, STEP on each change, BUSY=1.
REQ-032 SHALL verify: MODE=01, DIR=1, PERIOD=2 -> LED 1000,0100,0010,0001, then LED=0 with DONE pulsed for 1 cycle, BUSY=0.
REQ-033 SHALL verify: PERIOD=0 -> channel advances every cycle, STEP high every cycle after the first.
REQ-034 SHALL verify: START and STOP asserted together in RUN -> LED=0 and BUSY=0 next cycle, no DONE pulse.
REQ-035 SHALL verify: RN pulsed low mid-dwell -> outputs 0 immediately; with START held high through release, no restart occurs.
REQ-036 SHALL verify: macro defined, CH=3, MODE=10, PERIOD=1 -> LED 001,010,100,010,001,010; macro undefined -> 001,010,100,001.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED step sequencer: FSM states, MODE
// encodings, legal channel-count range and the latched run configuration.
package led_seq_pkg;

    localparam int unsigned CH_MIN = 2;
    localparam int unsigned CH_MAX = 16;

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONEPASS  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_LOOP_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic       dir;
    } seq_cfg_t;

endpackage

// File: rtl/led_seq_dwell_timer.sv
// Dwell counter for one LED step: counts 0..period-1 while enabled and wraps,
// flagging the terminal count combinationally so the sequencer advances on it.
module led_seq_dwell_timer #(
    parameter int unsigned PW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [PW-1:0] i_period,
    output logic          o_tc_c
);

    logic [PW-1:0] r_cnt;

    assign o_tc_c = i_en && (r_cnt == (i_period - PW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc_c ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/led_step_sequencer.sv
// One-hot LED chaser with loop / one-pass modes and START-edge restart.
// Define LED_SEQ_PINGPONG_EN to run MODE=10 as ping-pong; otherwise it loops.
module led_step_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CH = 4,
    parameter int unsigned PW = 24
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic          START,
    input  logic          STOP,
    input  logic [1:0]    MODE,
    input  logic          DIR,
    input  logic [PW-1:0] PERIOD,
    output logic [CH-1:0] LED,
    output logic          BUSY,
    output logic          STEP,
    output logic          DONE
);

    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(CH - 1);

    if (CH < CH_MIN || CH > CH_MAX) begin : g_ch_range
        $error("led_step_sequencer: CH out of legal range");
    end

    seq_state_e    r_state,  w_state_nxt;
    seq_cfg_t      r_cfg,    w_cfg_nxt;
    logic [PW-1:0] r_period, w_period_nxt;
    logic [IW-1:0] r_idx,    w_idx_nxt;
    logic [CH-1:0] r_led,    w_led_nxt;
    logic          r_busy,   w_busy_nxt;
    logic          r_step,   w_step_nxt;
    logic          r_done,   w_done_nxt;
    logic          r_start_q;
    logic          r_armed;
`ifdef LED_SEQ_PINGPONG_EN
    logic          r_rev,    w_rev_nxt;
`endif

    logic          w_start_edge;
    logic          w_tc;
    logic          w_tmr_clr;
    logic          w_at_end;
    logic [IW-1:0] w_idx_fwd;

    // r_armed stays low for the first cycle after reset so a START level held
    // through reset release is absorbed into r_start_q instead of firing.
    assign w_start_edge = START && !r_start_q && r_armed;

    assign w_at_end  = r_cfg.dir ? (r_idx == '0) : (r_idx == IDX_LAST);
    assign w_idx_fwd = r_cfg.dir ? ((r_idx == '0)      ? IDX_LAST : r_idx - IW'(1))
                                 : ((r_idx == IDX_LAST) ? '0       : r_idx + IW'(1));

    led_seq_dwell_timer #(
        .PW (PW)
    ) u_dwell (
        .clk      (CLK),
        .rst_n    (RN),
        .i_clr    (w_tmr_clr),
        .i_en     (r_state == ST_RUN),
        .i_period (r_period),
        .o_tc_c   (w_tc)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state   <= ST_IDLE;
            r_cfg     <= '0;
            r_period  <= PW'(1);
            r_idx     <= '0;
            r_led     <= '0;
            r_busy    <= 1'b0;
            r_step    <= 1'b0;
            r_done    <= 1'b0;
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
            r_rev     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cfg     <= w_cfg_nxt;
            r_period  <= w_period_nxt;
            r_idx     <= w_idx_nxt;
            r_led     <= w_led_nxt;
            r_busy    <= w_busy_nxt;
            r_step    <= w_step_nxt;
            r_done    <= w_done_nxt;
            r_start_q <= START;
            r_armed   <= 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
            r_rev     <= w_rev_nxt;
`endif
        end
    end

    // Next-state: STOP beats a START edge, which beats a dwell expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_cfg_nxt    = r_cfg;
        w_period_nxt = r_period;
        w_idx_nxt    = r_idx;
        w_step_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_tmr_clr    = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
        w_rev_nxt    = r_rev;
`endif

        if (STOP) begin
            w_state_nxt = ST_IDLE;
            w_tmr_clr   = 1'b1;
        end else if (w_start_edge) begin
            w_state_nxt  = ST_RUN;
            w_cfg_nxt    = '{mode: MODE, dir: DIR};
            w_period_nxt = (PERIOD == '0) ? PW'(1) : PERIOD;
            w_idx_nxt    = DIR ? IDX_LAST : '0;
            w_tmr_clr    = 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
            w_rev_nxt    = DIR;
`endif
        end else if (r_state == ST_RUN && w_tc) begin
            case (r_cfg.mode)
                MODE_ONEPASS: begin
                    if (w_at_end) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt  = w_idx_fwd;
                        w_step_nxt = 1'b1;
                    end
                end
`ifdef LED_SEQ_PINGPONG_EN
                MODE_PINGPONG: begin
                    w_step_nxt = 1'b1;
                    if (!r_rev && r_idx == IDX_LAST) begin
                        w_idx_nxt = r_idx - IW'(1);
                        w_rev_nxt = 1'b1;
                    end else if (r_rev && r_idx == '0) begin
                        w_idx_nxt = r_idx + IW'(1);
                        w_rev_nxt = 1'b0;
                    end else begin
                        w_idx_nxt = r_rev ? r_idx - IW'(1) : r_idx + IW'(1);
                    end
                end
                MODE_LOOP, MODE_LOOP_ALT: begin
                    w_idx_nxt  = w_idx_fwd;
                    w_step_nxt = 1'b1;
                end
`else
                MODE_LOOP, MODE_PINGPONG, MODE_LOOP_ALT: begin
                    w_idx_nxt  = w_idx_fwd;
                    w_step_nxt = 1'b1;
                end
`endif
            endcase
        end

        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_led_nxt  = w_busy_nxt ? (CH'(1) << w_idx_nxt) : '0;
    end

    assign LED  = r_led;
    assign BUSY = r_busy;
    assign STEP = r_step;
    assign DONE = r_done;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge
// monitor pops and compares them against a CH=4 and a CH=3 sequencer.
module tb_led_step_sequencer;

    typedef struct {
        logic [3:0] led;
        logic       busy;
        logic       step;
        logic       done;
        string      tag;
    } exp_t;

    logic        CLK;
    logic        RN;
    logic        START4, STOP4, DIR4;
    logic [1:0]  MODE4;
    logic [23:0] PERIOD4;
    logic [3:0]  LED4;
    logic        BUSY4, STEP4, DONE4;
    logic        START3, STOP3, DIR3;
    logic [1:0]  MODE3;
    logic [23:0] PERIOD3;
    logic [2:0]  LED3;
    logic        BUSY3, STEP3, DONE3;

    exp_t  q4[$];
    exp_t  q3[$];
    string cur_tag;
    int    n_tests;
    int    n_fail;

    led_step_sequencer #(.CH(4), .PW(24)) u_dut4 (
        .CLK(CLK), .RN(RN), .START(START4), .STOP(STOP4), .MODE(MODE4), .DIR(DIR4),
        .PERIOD(PERIOD4), .LED(LED4), .BUSY(BUSY4), .STEP(STEP4), .DONE(DONE4)
    );

    led_step_sequencer #(.CH(3), .PW(24)) u_dut3 (
        .CLK(CLK), .RN(RN), .START(START3), .STOP(STOP3), .MODE(MODE3), .DIR(DIR3),
        .PERIOD(PERIOD3), .LED(LED3), .BUSY(BUSY3), .STEP(STEP3), .DONE(DONE3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push(input bit d3, input logic [3:0] led, input logic busy,
                        input logic step, input logic done);
        exp_t e;
        e.led = led; e.busy = busy; e.step = step; e.done = done; e.tag = cur_tag;
        if (d3) q3.push_back(e);
        else    q4.push_back(e);
    endtask

    task automatic hold(input bit d3, input logic [3:0] led, input int n, input logic step_first);
        for (int i = 0; i < n; i++) push(d3, led, 1'b1, (i == 0) ? step_first : 1'b0, 1'b0);
    endtask

    task automatic idle(input bit d3, input int n);
        for (int i = 0; i < n; i++) push(d3, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string dut, input exp_t e, input logic [3:0] led,
                         input logic busy, input logic step, input logic done);
        n_tests++;
        if (led !== e.led || busy !== e.busy || step !== e.step || done !== e.done) begin
            n_fail++;
            $display("FAIL %s %s @%0t: got led=%b busy=%b step=%b done=%b, want led=%b busy=%b step=%b done=%b",
                     e.tag, dut, $time, led, busy, step, done, e.led, e.busy, e.step, e.done);
        end
    endtask

    // Monitor: one expectation per cycle per DUT while its queue holds entries.
    always @(negedge CLK) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            check("dut4", e, LED4, BUSY4, STEP4, DONE4);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("dut3", e, {1'b0, LED3}, BUSY3, STEP3, DONE3);
        end
    end

    initial begin
        n_tests = 0; n_fail = 0;
        RN = 1'b0;
        START4 = 0; STOP4 = 0; DIR4 = 0; MODE4 = 2'b00; PERIOD4 = 24'd0;
        START3 = 0; STOP3 = 0; DIR3 = 0; MODE3 = 2'b00; PERIOD3 = 24'd0;
        @(posedge CLK); #1;

        cur_tag = "reset";
        idle(0, 2); idle(1, 2);
        cyc(2);
        RN = 1'b1;
        idle(0, 2); idle(1, 2);
        cyc(2);

        // Loop ascending, PERIOD=3, with wrap back to LED[0]
        cur_tag = "loop_p3";
        MODE4 = 2'b00; DIR4 = 0; PERIOD4 = 24'd3; START4 = 1;
        idle(0, 1);
        hold(0, 4'b0001, 3, 0); hold(0, 4'b0010, 3, 1); hold(0, 4'b0100, 3, 1);
        hold(0, 4'b1000, 3, 1); hold(0, 4'b0001, 2, 1);
        cyc(1); START4 = 0; MODE4 = 2'b01; DIR4 = 1; PERIOD4 = 24'd7;
        cyc(14);
        cur_tag = "stop_with_start";
        STOP4 = 1; START4 = 1;
        push(0, 4'b0001, 1, 0, 0); idle(0, 3);
        cyc(1); STOP4 = 0; START4 = 0;
        cyc(3);

        // One-pass descending, PERIOD=2, DONE then IDLE
        cur_tag = "onepass_desc";
        MODE4 = 2'b01; DIR4 = 1; PERIOD4 = 24'd2; START4 = 1;
        idle(0, 1);
        hold(0, 4'b1000, 2, 0); hold(0, 4'b0100, 2, 1);
        hold(0, 4'b0010, 2, 1); hold(0, 4'b0001, 2, 1);
        push(0, 4'b0000, 0, 0, 1); idle(0, 2);
        cyc(1); START4 = 0;
        cyc(11);

        // PERIOD=0 behaves as 1: advance every cycle
        cur_tag = "period0";
        MODE4 = 2'b00; DIR4 = 0; PERIOD4 = 24'd0; START4 = 1;
        idle(0, 1);
        hold(0, 4'b0001, 1, 0); hold(0, 4'b0010, 1, 1); hold(0, 4'b0100, 1, 1);
        hold(0, 4'b1000, 1, 1); hold(0, 4'b0001, 1, 1); hold(0, 4'b0010, 1, 1);
        cyc(1); START4 = 0;
        cyc(6);
        STOP4 = 1;
        push(0, 4'b0100, 1, 1, 0); idle(0, 2);
        cyc(1); STOP4 = 0;
        cyc(2);

        // START edge during RUN restarts with new settings, no STEP
        cur_tag = "restart";
        MODE4 = 2'b00; DIR4 = 0; PERIOD4 = 24'd3; START4 = 1;
        idle(0, 1);
        hold(0, 4'b0001, 3, 0); hold(0, 4'b0010, 2, 1);
        cyc(1); START4 = 0;
        cyc(5);
        DIR4 = 1; PERIOD4 = 24'd2; START4 = 1;
        push(0, 4'b0010, 1, 0, 0);
        hold(0, 4'b1000, 2, 0); hold(0, 4'b0100, 1, 1);
        cyc(1); START4 = 0;
        cyc(3);
        STOP4 = 1;
        push(0, 4'b0100, 1, 0, 0); idle(0, 2);
        cyc(1); STOP4 = 0;
        cyc(2);

        // Reset mid-dwell with START held high through release
        cur_tag = "reset_middwell";
        MODE4 = 2'b00; DIR4 = 0; PERIOD4 = 24'd5; START4 = 1;
        idle(0, 1); hold(0, 4'b0001, 3, 0);
        cyc(4);
        RN = 1'b0;
        idle(0, 2);
        cyc(2);
        RN = 1'b1;
        idle(0, 4);
        cyc(4);
        START4 = 0;
        idle(0, 2);
        cyc(2);

        // MODE=10 on CH=3: ping-pong when enabled, plain loop otherwise
        cur_tag = "mode10_ch3";
        MODE3 = 2'b10; DIR3 = 0; PERIOD3 = 24'd1; START3 = 1;
        idle(1, 1);
        hold(1, 4'b0001, 1, 0); hold(1, 4'b0010, 1, 1); hold(1, 4'b0100, 1, 1);
`ifdef LED_SEQ_PINGPONG_EN
        hold(1, 4'b0010, 1, 1); hold(1, 4'b0001, 1, 1); hold(1, 4'b0010, 1, 1);
`else
        hold(1, 4'b0001, 1, 1); hold(1, 4'b0010, 1, 1); hold(1, 4'b0100, 1, 1);
`endif
        cyc(1); START3 = 0;
        cyc(6);
        STOP3 = 1;
`ifdef LED_SEQ_PINGPONG_EN
        push(1, 4'b0100, 1, 1, 0);
`else
        push(1, 4'b0001, 1, 1, 0);
`endif
        idle(1, 2);
        cyc(1); STOP3 = 0;
        cyc(3);

        if (q4.size() != 0 || q3.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0", q4.size(), q3.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
